// File: rtl/priority_finder_core.sv
// Priority finder: lowest/highest set bit of data_in, zero-latency result plus a 1-cycle registered copy; no backpressure.
// Optional combinational onehot output is enabled by defining PRIORITY_FINDER_ONEHOT_EN.
module priority_finder_core #(
   parameter int FIRST_PRIORITY = 1,
   parameter int WIDTH          = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         data_in,
   output logic [$clog2(WIDTH)-1:0] index,
   output logic                     index_valid,
   output logic [$clog2(WIDTH)-1:0] index_r,
   output logic                     index_valid_r
`ifdef PRIORITY_FINDER_ONEHOT_EN
   ,
   output logic [WIDTH-1:0]         onehot
`endif
);

   localparam int IW = $clog2(WIDTH);

   logic [IW-1:0] w_index;
   logic          w_valid;
   logic [IW-1:0] r_index;
   logic          r_valid;

   // The scan direction is chosen so the last hit written is the winner;
   // with no bit set the default of zero survives.
   always_comb begin
      w_index = '0;
      if (FIRST_PRIORITY != 0) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (data_in[i]) w_index = IW'(i);
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (data_in[i]) w_index = IW'(i);
         end
      end
   end

   assign w_valid     = |data_in;
   assign index       = w_index;
   assign index_valid = w_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_index <= '0;
         r_valid <= 1'b0;
      end else begin
         r_index <= w_index;
         r_valid <= w_valid;
      end
   end

   assign index_r       = r_index;
   assign index_valid_r = r_valid;

`ifdef PRIORITY_FINDER_ONEHOT_EN
   logic [WIDTH-1:0] w_onehot;

   always_comb begin
      w_onehot = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (w_valid && (w_index == IW'(i))) w_onehot[i] = 1'b1;
      end
   end

   assign onehot = w_onehot;
`endif

endmodule

// File: tb/tb_priority_finder_core.sv
// Directed bench for priority_finder_core: lowest-first and highest-first at WIDTH=4, highest-first at WIDTH=5.
module tb_priority_finder_core;

   logic       clk;
   logic       rst;
   logic [3:0] d4;
   logic [4:0] d5;

   logic [1:0] lo_index, lo_index_r, hi_index, hi_index_r;
   logic       lo_valid, lo_valid_r, hi_valid, hi_valid_r;
   logic [2:0] w5_index, w5_index_r;
   logic       w5_valid, w5_valid_r;
`ifdef PRIORITY_FINDER_ONEHOT_EN
   logic [3:0] lo_onehot, hi_onehot;
   logic [4:0] w5_onehot;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   // Hand-computed expected indices for data_in = 0..15.
   int exp_lo [16] = '{0, 0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0};
   int exp_hi [16] = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};

   priority_finder_core #(.FIRST_PRIORITY(1), .WIDTH(4)) u_lo (
      .clk(clk), .rst(rst), .data_in(d4),
      .index(lo_index), .index_valid(lo_valid),
      .index_r(lo_index_r), .index_valid_r(lo_valid_r)
`ifdef PRIORITY_FINDER_ONEHOT_EN
      , .onehot(lo_onehot)
`endif
   );

   priority_finder_core #(.FIRST_PRIORITY(0), .WIDTH(4)) u_hi (
      .clk(clk), .rst(rst), .data_in(d4),
      .index(hi_index), .index_valid(hi_valid),
      .index_r(hi_index_r), .index_valid_r(hi_valid_r)
`ifdef PRIORITY_FINDER_ONEHOT_EN
      , .onehot(hi_onehot)
`endif
   );

   priority_finder_core #(.FIRST_PRIORITY(0), .WIDTH(5)) u_w5 (
      .clk(clk), .rst(rst), .data_in(d5),
      .index(w5_index), .index_valid(w5_valid),
      .index_r(w5_index_r), .index_valid_r(w5_valid_r)
`ifdef PRIORITY_FINDER_ONEHOT_EN
      , .onehot(w5_onehot)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      d4  = 4'b0000;
      d5  = 5'b00000;

      // Combinational sweep of both WIDTH=4 variants.
      for (int v = 0; v < 16; v++) begin
         d4 = 4'(v);
         #1;
         check($sformatf("lo_index[%0d]", v), 32'(lo_index), 32'(exp_lo[v]));
         check($sformatf("lo_valid[%0d]", v), 32'(lo_valid), (v != 0) ? 32'd1 : 32'd0);
         check($sformatf("hi_index[%0d]", v), 32'(hi_index), 32'(exp_hi[v]));
         check($sformatf("hi_valid[%0d]", v), 32'(hi_valid), (v != 0) ? 32'd1 : 32'd0);
`ifdef PRIORITY_FINDER_ONEHOT_EN
         check($sformatf("lo_onehot[%0d]", v), 32'(lo_onehot),
               (v != 0) ? (32'd1 << exp_lo[v]) : 32'd0);
`endif
      end

`ifdef PRIORITY_FINDER_ONEHOT_EN
      d4 = 4'b1110; #1;
      check("onehot_1110", 32'(lo_onehot), 32'b0010);
      d4 = 4'b0000; #1;
      check("onehot_0000", 32'(lo_onehot), 32'b0000);
`endif

      // Reset held two cycles with a live request: reset wins over sampling.
      d4 = 4'b0110;
      repeat (2) @(posedge clk);
      #1;
      check("rst_lo_index_r", 32'(lo_index_r), 32'd0);
      check("rst_lo_valid_r", 32'(lo_valid_r), 32'd0);
      check("rst_hi_valid_r", 32'(hi_valid_r), 32'd0);

      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_lo_index_r", 32'(lo_index_r), 32'd1);
      check("post_rst_lo_valid_r", 32'(lo_valid_r), 32'd1);
      check("post_rst_hi_index_r", 32'(hi_index_r), 32'd2);

      d4 = 4'b0000; #1;
      check("lag_lo_index_r_held", 32'(lo_index_r), 32'd1);
      @(posedge clk); #1;
      check("zero_lo_valid_r", 32'(lo_valid_r), 32'd0);
      check("zero_lo_index_r", 32'(lo_index_r), 32'd0);

      // Reset pulse mid-stream with a steady request.
      d4 = 4'b1000;
      @(posedge clk); #1;
      check("steady_lo_index_r", 32'(lo_index_r), 32'd3);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_lo_index_r", 32'(lo_index_r), 32'd0);
      check("mid_rst_lo_valid_r", 32'(lo_valid_r), 32'd0);
      check("mid_rst_lo_index", 32'(lo_index), 32'd3);
      check("mid_rst_lo_valid", 32'(lo_valid), 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;
      check("after_rst_lo_index_r", 32'(lo_index_r), 32'd3);
      check("after_rst_lo_valid_r", 32'(lo_valid_r), 32'd1);

      // Non-power-of-two width, highest-first.
      d5 = 5'b10000; #1;
      check("w5_10000", 32'(w5_index), 32'd4);
      d5 = 5'b00110; #1;
      check("w5_00110", 32'(w5_index), 32'd2);
      d5 = 5'b00001; #1;
      check("w5_00001", 32'(w5_index), 32'd0);
      d5 = 5'b11111; #1;
      check("w5_11111", 32'(w5_index), 32'd4);
      check("w5_valid_11111", 32'(w5_valid), 32'd1);
      @(posedge clk); #1;
      check("w5_index_r", 32'(w5_index_r), 32'd4);
      d5 = 5'b00000; #1;
      check("w5_zero_index", 32'(w5_index), 32'd0);
      check("w5_zero_valid", 32'(w5_valid), 32'd0);
`ifdef PRIORITY_FINDER_ONEHOT_EN
      d5 = 5'b00110; #1;
      check("w5_onehot_00110", 32'(w5_onehot), 32'b00100);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
